conv3x3_engine: RTL

Downstream consumer of the 3x3 window fetcher on the 128x128 8-bit image path. Scans output pixels in raster order and requests one zero-padded window per pixel through the fetcher's start/start_addr/finish handshake. Applies a signed 3x3 kernel plus bias, then ReLU, right shift and saturation, and writes one 8-bit result per pixel to the result memory.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv3x3_mac.sv | 32 +++
 rtl/conv3x3_engine.sv | 131 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution engine: state encoding and
// datapath widths for the 128x128 8-bit image path.
package conv_pkg;

  localparam int IMG_BITS   = 7;
  localparam int LAST_COORD = 127;
  localparam int ACC_W      = 22;
  localparam int PIX_W      = 8;
  localparam int W_W        = 8;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_REQ   = 4'd1,
    S_WAIT  = 4'd2,
    S_MAC   = 4'd3,
    S_WRITE = 4'd4,
    S_DONE  = 4'd5
  } state_t;

endpackage

// File: rtl/conv3x3_mac.sv
// Combinational 9-tap signed multiply-accumulate plus bias.
// Tap (8-k) pairs with weight k, so tap 8 (top-left) meets w[0].
module conv3x3_mac
  import conv_pkg::*;
(
  input  logic [9*PIX_W-1:0]       taps_i,
  input  logic [9*W_W-1:0]         weights_i,
  input  logic [15:0]              bias_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [PIX_W:0]       pix;
  logic signed [W_W-1:0]       wt;
  logic signed [PIX_W+W_W:0]   prod;
  logic signed [ACC_W-1:0]     acc;

  // Sum of unsigned pixels times signed weights, seeded with the bias.
  always_comb begin
    pix  = '0;
    wt   = '0;
    prod = '0;
    acc  = ACC_W'(signed'(bias_i));
    for (int k = 0; k < 9; k++) begin
      pix  = signed'({1'b0, taps_i[PIX_W*(8-k) +: PIX_W]});
      wt   = signed'(weights_i[W_W*k +: W_W]);
      prod = pix * wt;
      acc  = acc + ACC_W'(prod);
    end
    sum_o = acc;
  end

endmodule

// File: rtl/conv3x3_engine.sv
// Raster-scan 3x3 convolution: requests one padded window per output pixel
// from the window fetcher, applies kernel+bias, ReLU, shift and saturation,
// and writes one 8-bit result per pixel.
//
// state   | meaning
// IDLE    | waiting for go; kernel and bias latched on go
// REQ     | one-cycle fetch_start for pixel {y,x}
// WAIT    | waiting for fetch_finish; taps captured on it
// MAC     | accumulator loaded with bias + weighted taps
// WRITE   | one-cycle o_we with post-processed result, advance x/y
// DONE    | one-cycle end-of-frame pulse
module conv3x3_engine #(
  parameter int SHIFT    = 4,
  parameter int IMG_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [71:0]           weights,
  input  logic [15:0]           bias,
  output logic                  fetch_start,
  output logic [2*IMG_BITS-1:0] fetch_addr,
  input  logic                  fetch_finish,
  input  logic [71:0]           win_taps,
  output logic                  o_we,
  output logic [2*IMG_BITS-1:0] o_addr,
  output logic [7:0]            o_data,
  output logic                  busy,
  output logic                  done
);

  import conv_pkg::*;

  state_t                  state_q, state_d;
  logic [IMG_BITS-1:0]     x_q, y_q;
  logic [71:0]             w_q;
  logic [15:0]             b_q;
  logic [71:0]             taps_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] mac_sum;
  logic [2*IMG_BITS-1:0]   o_addr_q;
  logic                    last_px;

  conv3x3_mac u_mac (
    .taps_i    (taps_q),
    .weights_i (w_q),
    .bias_i    (b_q),
    .sum_o     (mac_sum)
  );

  // Negative sums clamp to zero; shifted result saturates at 255.
  function automatic logic [7:0] relu_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a >>> SHIFT;
    if (a < 0)
      return 8'd0;
    else if (r > ACC_W'(255))
      return 8'hFF;
    else
      return r[7:0];
  endfunction

  assign last_px = (x_q == IMG_BITS'(LAST_COORD)) && (y_q == IMG_BITS'(LAST_COORD));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (fetch_finish) state_d = S_MAC;
      S_MAC:   state_d = S_WRITE;
      S_WRITE: state_d = last_px ? S_DONE : S_REQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: kernel capture, taps, accumulator, scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      b_q      <= '0;
      taps_q   <= '0;
      acc_q    <= '0;
      o_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            w_q <= weights;
            b_q <= bias;
            x_q <= '0;
            y_q <= '0;
          end
        end
        S_WAIT: begin
          if (fetch_finish) taps_q <= win_taps;
        end
        S_MAC: begin
          acc_q    <= mac_sum;
          o_addr_q <= {y_q, x_q};
        end
        S_WRITE: begin
          if (!last_px) begin
            x_q <= x_q + IMG_BITS'(1);
            if (x_q == IMG_BITS'(LAST_COORD)) y_q <= y_q + IMG_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fetch_start = (state_q == S_REQ);
  assign fetch_addr  = {y_q, x_q};
  assign o_we        = (state_q == S_WRITE);
  assign o_addr      = o_addr_q;
  assign o_data      = relu_sat(acc_q);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule
